pipe_ctrl_unit: RTL and testbench

//  Pipelined control unit for the 5-stage MIPS-subset CPU. Decodes the ID-stage opcode,

---
 rtl/pipe_ctrl_unit_pkg.sv | 61 ++++++
 rtl/pipe_ctrl_unit_op_decode.sv | 49 ++++
 rtl/pipe_ctrl_unit.sv | 94 +++++++++
 tb/tb_pipe_ctrl_unit.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// Shared opcode / ALU_op encodings and the control bundles carried down the pipeline.
package ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [2:0] ALUOP_MEM  = 3'b000;
  localparam logic [2:0] ALUOP_BR   = 3'b001;
  localparam logic [2:0] ALUOP_R    = 3'b010;
  localparam logic [2:0] ALUOP_SLTI = 3'b011;
  localparam logic [2:0] ALUOP_ADDI = 3'b100;

  // Field order fixes the bundle bit positions, MSB first.
  typedef struct packed {
    logic [2:0] aluOp;
    logic       aluSrc;
    logic       regWrite;
    logic       regDst;
    logic       branch;
    logic       branchNe;
    logic       memRead;
    logic       memToReg;
    logic       memWrite;
  } ctrl_t;

  typedef struct packed {
    logic branch;
    logic branchNe;
    logic memRead;
    logic memWrite;
    logic regWrite;
    logic memToReg;
  } memCtrl_t;

  typedef struct packed {
    logic regWrite;
    logic memToReg;
  } wbCtrl_t;

  function automatic ctrl_t mkCtrl(logic [2:0] aluOp, logic aluSrc, logic regWrite,
                                   logic regDst, logic branch, logic branchNe,
                                   logic memRead, logic memToReg, logic memWrite);
    ctrl_t c;
    c.aluOp    = aluOp;
    c.aluSrc   = aluSrc;
    c.regWrite = regWrite;
    c.regDst   = regDst;
    c.branch   = branch;
    c.branchNe = branchNe;
    c.memRead  = memRead;
    c.memToReg = memToReg;
    c.memWrite = memWrite;
    return c;
  endfunction

endpackage

// File: rtl/pipe_ctrl_unit_op_decode.sv
// Combinational ID-stage decode: opcode to control bundle, plus illegal and rt-usage flags.
module op_decode
  import ctrl_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int EN_BNE = 1
) (
  input  logic            idValid,
  input  logic [OP_W-1:0] opcode,
  output ctrl_t           ctrl,
  output logic            illegal,
  output logic            usesRt
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    usesRt  = 1'b0;
    if (idValid) begin
      case (opcode)
        OP_R: begin
          ctrl   = mkCtrl(ALUOP_R, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
          usesRt = 1'b1;
        end
        OP_ADDI: ctrl = mkCtrl(ALUOP_ADDI, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        OP_SLTI: ctrl = mkCtrl(ALUOP_SLTI, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        OP_BEQ: begin
          ctrl   = mkCtrl(ALUOP_BR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
          usesRt = 1'b1;
        end
        OP_BNE: begin
          if (EN_BNE != 0) begin
            ctrl   = mkCtrl(ALUOP_BR, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            usesRt = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
        OP_LW: ctrl = mkCtrl(ALUOP_MEM, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        OP_SW: begin
          ctrl   = mkCtrl(ALUOP_MEM, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
          usesRt = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control: ID decode, ID/EX, EX/MEM, MEM/WB control registers, load-use stall
// and branch flush.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 6,
  parameter int ALUOP_W = 3,
  parameter int RADDR_W = 5,
  parameter int EN_BNE  = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               id_valid_i,
  input  logic [OP_W-1:0]    instr_op_i,
  input  logic [RADDR_W-1:0] id_rs_i,
  input  logic [RADDR_W-1:0] id_rt_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               illegal_o,
  output logic [ALUOP_W-1:0] ex_alu_op_o,
  output logic               ex_alusrc_o,
  output logic               ex_regdst_o,
  output logic               ex_memread_o,
  output logic               mem_branch_o,
  output logic               mem_branch_ne_o,
  output logic               mem_memread_o,
  output logic               mem_memwrite_o,
  output logic               wb_regwrite_o,
  output logic               wb_memtoreg_o
);

  ctrl_t              idCtrl;
  logic               idUsesRt;
  ctrl_t              idEx;
  logic [RADDR_W-1:0] exRtQ;
  memCtrl_t           exMem;
  wbCtrl_t            memWb;

  op_decode #(.OP_W(OP_W), .EN_BNE(EN_BNE)) uDecode (
    .idValid (id_valid_i),
    .opcode  (instr_op_i),
    .ctrl    (idCtrl),
    .illegal (illegal_o),
    .usesRt  (idUsesRt)
  );

  // Load in EX whose destination feeds the ID instruction; r0 never creates a dependency.
  assign stall_o = id_valid_i & idEx.memRead & (exRtQ != '0) &
                   ((exRtQ == id_rs_i) | (idUsesRt & (exRtQ == id_rt_i)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      idEx  <= '0;
      exRtQ <= '0;
      exMem <= '0;
      memWb <= '0;
    end else begin
      if (flush_i || stall_o) begin
        idEx  <= '0;
        exRtQ <= '0;
      end else begin
        idEx  <= idCtrl;
        exRtQ <= id_rt_i;
      end

      if (flush_i) begin
        exMem <= '0;
      end else begin
        exMem.branch   <= idEx.branch;
        exMem.branchNe <= idEx.branchNe;
        exMem.memRead  <= idEx.memRead;
        exMem.memWrite <= idEx.memWrite;
        exMem.regWrite <= idEx.regWrite;
        exMem.memToReg <= idEx.memToReg;
      end

      // The branch in MEM still retires, so MEM/WB always advances.
      memWb.regWrite <= exMem.regWrite;
      memWb.memToReg <= exMem.memToReg;
    end
  end

  assign ex_alu_op_o     = ALUOP_W'(idEx.aluOp);
  assign ex_alusrc_o     = idEx.aluSrc;
  assign ex_regdst_o     = idEx.regDst;
  assign ex_memread_o    = idEx.memRead;
  assign mem_branch_o    = exMem.branch;
  assign mem_branch_ne_o = exMem.branchNe;
  assign mem_memread_o   = exMem.memRead;
  assign mem_memwrite_o  = exMem.memWrite;
  assign wb_regwrite_o   = memWb.regWrite;
  assign wb_memtoreg_o   = memWb.memToReg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: per-cycle vector table plus a mid-pipeline reset sequence.
module tb_pipe_ctrl_unit;

  localparam logic [5:0] O_R    = 6'b000000;
  localparam logic [5:0] O_ADDI = 6'b001000;
  localparam logic [5:0] O_SLTI = 6'b001010;
  localparam logic [5:0] O_BEQ  = 6'b000100;
  localparam logic [5:0] O_BNE  = 6'b000101;
  localparam logic [5:0] O_LW   = 6'b100011;
  localparam logic [5:0] O_SW   = 6'b101011;
  localparam logic [5:0] O_BAD  = 6'b111111;

  // ex slice {alu_op, alusrc, regdst, memread}
  localparam logic [5:0] E0     = 6'b000_0_0_0;
  localparam logic [5:0] E_R    = 6'b010_0_1_0;
  localparam logic [5:0] E_ADDI = 6'b100_1_0_0;
  localparam logic [5:0] E_SLTI = 6'b011_1_0_0;
  localparam logic [5:0] E_BEQ  = 6'b001_0_0_0;
  localparam logic [5:0] E_BNE  = 6'b001_0_0_0;
  localparam logic [5:0] E_LW   = 6'b000_1_0_1;
  localparam logic [5:0] E_SW   = 6'b000_1_0_0;
  // mem slice {branch, branch_ne, memread, memwrite}
  localparam logic [3:0] M0     = 4'b0000;
  localparam logic [3:0] M_BEQ  = 4'b1000;
  localparam logic [3:0] M_BNE  = 4'b0100;
  localparam logic [3:0] M_LW   = 4'b0010;
  localparam logic [3:0] M_SW   = 4'b0001;
  // wb slice {regwrite, memtoreg}
  localparam logic [1:0] W0     = 2'b00;
  localparam logic [1:0] W_ALU  = 2'b10;
  localparam logic [1:0] W_LW   = 2'b11;

  typedef struct {
    logic       v;
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       fl;
    logic       st;
    logic       il;
    logic       ilB;
    logic [5:0] ex;
    logic [3:0] mem;
    logic [1:0] wb;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       idValid = 1'b0;
  logic [5:0] op = '0;
  logic [4:0] rs = '0;
  logic [4:0] rt = '0;
  logic       flush = 1'b0;

  logic       stall, illegal, exAluSrc, exRegDst, exMemRd;
  logic [2:0] exAluOp;
  logic       memBr, memBrNe, memRd, memWr, wbRegWr, wbMemToReg;

  logic       stallB, illegalB, exAluSrcB, exRegDstB, exMemRdB;
  logic [2:0] exAluOpB;
  logic       memBrB, memBrNeB, memRdB, memWrB, wbRegWrB, wbMemToRegB;

  int total = 0;
  int bad = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  pipe_ctrl_unit dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .instr_op_i(op),
    .id_rs_i(rs), .id_rt_i(rt), .flush_i(flush),
    .stall_o(stall), .illegal_o(illegal),
    .ex_alu_op_o(exAluOp), .ex_alusrc_o(exAluSrc), .ex_regdst_o(exRegDst),
    .ex_memread_o(exMemRd), .mem_branch_o(memBr), .mem_branch_ne_o(memBrNe),
    .mem_memread_o(memRd), .mem_memwrite_o(memWr),
    .wb_regwrite_o(wbRegWr), .wb_memtoreg_o(wbMemToReg)
  );

  pipe_ctrl_unit #(.EN_BNE(0)) dutNoBne (
    .clk_i(clk), .rst_i(rst), .id_valid_i(idValid), .instr_op_i(op),
    .id_rs_i(rs), .id_rt_i(rt), .flush_i(flush),
    .stall_o(stallB), .illegal_o(illegalB),
    .ex_alu_op_o(exAluOpB), .ex_alusrc_o(exAluSrcB), .ex_regdst_o(exRegDstB),
    .ex_memread_o(exMemRdB), .mem_branch_o(memBrB), .mem_branch_ne_o(memBrNeB),
    .mem_memread_o(memRdB), .mem_memwrite_o(memWrB),
    .wb_regwrite_o(wbRegWrB), .wb_memtoreg_o(wbMemToRegB)
  );

  function automatic vec_t mk(logic v, logic [5:0] o, logic [4:0] s, logic [4:0] t, logic f,
                              logic st, logic il, logic ilB,
                              logic [5:0] ex, logic [3:0] mem, logic [1:0] wb);
    vec_t r;
    r.v = v; r.op = o; r.rs = s; r.rt = t; r.fl = f;
    r.st = st; r.il = il; r.ilB = ilB; r.ex = ex; r.mem = mem; r.wb = wb;
    return r;
  endfunction

  function automatic vec_t nop(logic [5:0] ex, logic [3:0] mem, logic [1:0] wb);
    return mk(1'b0, O_R, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ex, mem, wb);
  endfunction

  function automatic logic [14:0] observed();
    return {stall, illegal, illegalB, exAluOp, exAluSrc, exRegDst, exMemRd,
            memBr, memBrNe, memRd, memWr, wbRegWr, wbMemToReg};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] o, input logic [4:0] s,
                       input logic [4:0] t, input logic f);
    idValid = v; op = o; rs = s; rt = t; flush = f;
  endtask

  initial begin
    // addi, slti, R back-to-back
    tbl.push_back(mk(1, O_ADDI, 1, 2, 0, 0, 0, 0, E0,     M0, W0));
    tbl.push_back(mk(1, O_SLTI, 1, 3, 0, 0, 0, 0, E_ADDI, M0, W0));
    tbl.push_back(mk(1, O_R,    1, 4, 0, 0, 0, 0, E_SLTI, M0, W0));
    tbl.push_back(nop(E_R, M0, W_ALU));
    tbl.push_back(nop(E0,  M0, W_ALU));
    tbl.push_back(nop(E0,  M0, W_ALU));
    // lw rt=5 then R rs=5: one stall, bubble, R late
    tbl.push_back(mk(1, O_LW, 1, 5, 0, 0, 0, 0, E0,   M0,   W0));
    tbl.push_back(mk(1, O_R,  5, 6, 0, 1, 0, 0, E_LW, M0,   W0));
    tbl.push_back(mk(1, O_R,  5, 6, 0, 0, 0, 0, E0,   M_LW, W0));
    tbl.push_back(nop(E_R, M0, W_LW));
    tbl.push_back(nop(E0,  M0, W0));
    tbl.push_back(nop(E0,  M0, W_ALU));
    // lw rt=0 never stalls; addi does not use rt; sw does
    tbl.push_back(mk(1, O_LW,   1, 0, 0, 0, 0, 0, E0,     M0,   W0));
    tbl.push_back(mk(1, O_R,    0, 0, 0, 0, 0, 0, E_LW,   M0,   W0));
    tbl.push_back(mk(1, O_LW,   1, 5, 0, 0, 0, 0, E_R,    M_LW, W0));
    tbl.push_back(mk(1, O_ADDI, 1, 5, 0, 0, 0, 0, E_LW,   M0,   W_LW));
    tbl.push_back(mk(1, O_LW,   1, 7, 0, 0, 0, 0, E_ADDI, M_LW, W_ALU));
    tbl.push_back(mk(1, O_SW,   2, 7, 0, 1, 0, 0, E_LW,   M0,   W_LW));
    tbl.push_back(mk(1, O_SW,   2, 7, 0, 0, 0, 0, E0,     M_LW, W_ALU));
    tbl.push_back(nop(E_SW, M0,   W_LW));
    tbl.push_back(nop(E0,   M_SW, W0));
    tbl.push_back(nop(E0,   M0,   W0));
    // illegal opcode; bne legal only on the EN_BNE=1 instance
    tbl.push_back(mk(1, O_BAD, 0, 0, 0, 0, 1, 1, E0, M0, W0));
    tbl.push_back(mk(1, O_BNE, 1, 2, 0, 0, 0, 1, E0, M0, W0));
    tbl.push_back(nop(E_BNE, M0,    W0));
    tbl.push_back(nop(E0,    M_BNE, W0));
    // invalid ID slot neither decodes nor stalls
    tbl.push_back(mk(0, O_LW, 0, 0, 0, 0, 0, 0, E0,   M0, W0));
    tbl.push_back(mk(1, O_LW, 1, 5, 0, 0, 0, 0, E0,   M0, W0));
    tbl.push_back(mk(0, O_R,  5, 5, 0, 0, 0, 0, E_LW, M0, W0));
    tbl.push_back(nop(E0, M_LW, W0));
    tbl.push_back(nop(E0, M0,   W_LW));
    tbl.push_back(nop(E0, M0,   W0));
    // flush with sw in ID/EX and beq in EX/MEM
    tbl.push_back(mk(1, O_BEQ, 1, 2, 0, 0, 0, 0, E0,    M0,    W0));
    tbl.push_back(mk(1, O_SW,  3, 4, 0, 0, 0, 0, E_BEQ, M0,    W0));
    tbl.push_back(mk(0, O_R,   0, 0, 1, 0, 0, 0, E_SW,  M_BEQ, W0));
    tbl.push_back(nop(E0, M0, W0));
    tbl.push_back(nop(E0, M0, W0));
    // flush and stall together: stall still reported, flush kills the load
    tbl.push_back(mk(1, O_LW, 1, 5, 0, 0, 0, 0, E0,   M0, W0));
    tbl.push_back(mk(1, O_R,  5, 1, 1, 1, 0, 0, E_LW, M0, W0));
    tbl.push_back(nop(E0, M0, W0));
    tbl.push_back(nop(E0, M0, W0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk);
      #1 drive(tbl[i].v, tbl[i].op, tbl[i].rs, tbl[i].rt, tbl[i].fl);
      @(negedge clk);
      check($sformatf("row%0d", i), observed(),
            {tbl[i].st, tbl[i].il, tbl[i].ilB, tbl[i].ex, tbl[i].mem, tbl[i].wb});
    end

    // Reset asserted with a lw sitting in MEM
    @(posedge clk);
    #1 drive(1, O_LW, 1, 2, 0);
    @(posedge clk);
    #1 drive(0, O_R, 0, 0, 0);
    @(posedge clk);
    #1 check("lw_in_mem", observed(), {3'b000, E0, M_LW, W0});
    #2 rst = 1'b0;
    #1 check("reset_async", observed(), 15'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post_reset%0d", i), observed(), 15'd0);
    end
    @(posedge clk);
    #1 drive(1, O_ADDI, 1, 2, 0);
    @(negedge clk);
    check("first_decode_pre", observed(), {3'b000, E0, M0, W0});
    @(posedge clk);
    #1 drive(0, O_R, 0, 0, 0);
    @(negedge clk);
    check("first_decode_ex", observed(), {3'b000, E_ADDI, M0, W0});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
